nios_custom_dma_onchip_mem2: RTL
================================

NIOS_CUSTOM_DMA_ONCHIP_MEM2 -- requirements
Module: nios_custom_dma_onchip_mem2

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 32, word width; multiple of 8.
- ADDR_WIDTH, 15, word-address width.
- DEPTH, 20480, words implemented; DEPTH <= 2**ADDR_WIDTH.
- READ_LATENCY, 1, read latency in cycles; legal values 1 or 2.
- INIT_FILE, "nios_custom_dma_onchip_mem2.hex", power-up contents.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- clken  in  1  clock enable.
- reset_req  in  1  gates clock enable when high.
- s1_address, s2_address  in  ADDR_WIDTH  word address.
- s1_chipselect, s2_chipselect  in  1  port select.
- s1_read, s2_read  in  1  read request.
- s1_write, s2_write  in  1  write request.
- s1_byteenable, s2_byteenable  in  DATA_WIDTH/8  byte lanes.
- s1_writedata, s2_writedata  in  DATA_WIDTH  write data.
- s1_readdata, s2_readdata  out  DATA_WIDTH  read data.
- s1_readdatavalid, s2_readdatavalid  out  1  readdata qualifier.
- s1_waitrequest, s2_waitrequest  out  1  stall.
- clear_start  in  1  request memory zeroing.
- clear_busy  out  1  zeroing in progress.
- clear_done  out  1  one-cycle completion pulse.

Function
REQ-003 ce = clken & ~reset_req; when ce=0, no write, no clear step and no pipeline advance SHALL occur, and all outputs SHALL hold.
REQ-004 sN_waitrequest SHALL equal clear_busy; a request is accepted only when chipselect=1, ce=1 and waitrequest=0.
REQ-005 An accepted write SHALL update only the byte lanes whose byteenable bit is 1, visible to reads accepted in the next cycle onward.
REQ-006 An accepted read SHALL return data on sN_readdata with sN_readdatavalid=1 for exactly one ce cycle, READ_LATENCY ce cycles after acceptance.
REQ-007 Back-to-back reads SHALL be accepted every cycle, with one readdatavalid per read in order.
REQ-008 If read and write are both set on one port in one cycle, the write SHALL be performed and the read dropped, with no readdatavalid.
REQ-009 A read on one port at the address the other port writes in the same cycle SHALL return the old data.
REQ-010 If both ports write the same address in the same cycle, the s1 write SHALL take effect and the s2 write SHALL be discarded in full.
REQ-011 When address >= DEPTH, writes SHALL be ignored, and reads SHALL return all-zero data with readdatavalid asserted normally.
REQ-012 sN_readdata SHALL be zero whenever sN_readdatavalid=0.
REQ-013 The clear FSM SHALL have the states IDLE, CLEAR and DONE.
- IDLE -> CLEAR on clear_start=1 with ce=1; the clear address counter loads 0.
- CLEAR writes all-zero to the counter address once per ce cycle and increments; after address DEPTH-1 it moves to DONE.
- DONE lasts one cycle with clear_done=1, then returns to IDLE.
REQ-014 clear_busy SHALL be 1 exactly in CLEAR, giving DEPTH busy ce cycles.
REQ-015 clear_start SHALL be ignored in CLEAR and DONE.
REQ-016 A request presented in the same cycle as an accepted clear_start SHALL still be accepted.
REQ-017 Reads in flight when CLEAR is entered SHALL complete with pre-clear data.

Reset
REQ-018 While reset=1 at a clk edge:
- the FSM SHALL go to IDLE and the counter to 0;
- clear_busy, clear_done, waitrequest and readdatavalid SHALL be 0, and readdata all-zero;
- the read pipeline SHALL be flushed;
- reset SHALL take effect regardless of ce.
REQ-019 Reset SHALL NOT alter memory contents; a reset during CLEAR SHALL abort, leaving addresses below the counter zeroed and the rest unchanged.
REQ-020 Requests presented while reset=1 SHALL be discarded.

Verification
REQ-021 s1 writes 0xDEADBEEF to address 5 with byteenable 0xF, then s2 reads address 5 -> s2_readdata=0xDEADBEEF with valid 1 (LAT=1) or 2 (LAT=2) cycles after acceptance.
REQ-022 Address 7 holds 0x11223344, s1 writes 0xAABBCCDD with byteenable 0x5 -> a read returns 0x11BB33DD.
REQ-023 Both ports write address 9 in one cycle (s1 0x1, s2 0x2) -> a later read returns 0x1; s2 reads address 9 in that same cycle while s1 writes it -> old value returned.
REQ-024 clear_start with DEPTH=16 -> clear_busy=1 for 16 cycles, waitrequest high, then clear_done for 1 cycle; all 16 addresses read 0.
REQ-025 Reset pulsed at clear counter 8 (DEPTH=16) -> next cycle busy=0; addresses 0-7 read 0 and 8-15 hold prior data.
REQ-026 clken=0 for 3 cycles mid read burst -> readdatavalid and readdata hold, with no lost or duplicated beats; read of address 20480 -> data 0 with valid asserted.

Source files
------------

// File: rtl/nios_custom_dma_onchip_mem2.sv
// nios_custom_dma_onchip_mem2: dual-port byte-enabled RAM with pipelined reads and a zeroing engine
module nios_custom_dma_onchip_mem2 #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 15,
  parameter int DEPTH        = 20480,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "nios_custom_dma_onchip_mem2.hex"
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clken,
  input  logic                      reset_req,
  input  logic [ADDR_WIDTH-1:0]     s1_address,
  input  logic                      s1_chipselect,
  input  logic                      s1_read,
  input  logic                      s1_write,
  input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
  input  logic [DATA_WIDTH-1:0]     s1_writedata,
  output logic [DATA_WIDTH-1:0]     s1_readdata,
  output logic                      s1_readdatavalid,
  output logic                      s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]     s2_address,
  input  logic                      s2_chipselect,
  input  logic                      s2_read,
  input  logic                      s2_write,
  input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
  input  logic [DATA_WIDTH-1:0]     s2_writedata,
  output logic [DATA_WIDTH-1:0]     s2_readdata,
  output logic                      s2_readdatavalid,
  output logic                      s2_waitrequest,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      clear_done
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;
  state_t r_st, w_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic w_ce, w_busy, w_clr_we;
  logic [ADDR_WIDTH-1:0] w_addr [2];
  logic [IW-1:0] w_idx [2];
  logic [NB-1:0] w_be [2];
  logic [DATA_WIDTH-1:0] w_wd [2];
  logic [DATA_WIDTH-1:0] w_rdat [2];
  logic [1:0] w_acc, w_inr, w_rd, w_wr, w_we, w_rv;
  if ($bits(INIT_FILE) == 0) begin : g_no_init_file
  end
  assign w_ce = clken & ~reset_req;
  assign w_busy = r_st == S_CLEAR;
  assign w_clr_we = w_busy & w_ce & ~reset;
  // gather both ports into arrays and decide which requests are accepted; s1 wins a same-address write clash
  always_comb begin
    w_addr[0] = s1_address;
    w_addr[1] = s2_address;
    w_be[0] = s1_byteenable;
    w_be[1] = s2_byteenable;
    w_wd[0] = s1_writedata;
    w_wd[1] = s2_writedata;
    for (int i = 0; i < 2; i++) begin
      w_inr[i] = {1'b0, w_addr[i]} < DEPTH_X;
      w_idx[i] = w_addr[i][IW-1:0];
    end
    w_acc = {s2_chipselect, s1_chipselect} & {2{w_ce & ~w_busy & ~reset}};
    w_rd = w_acc & {s2_read, s1_read} & ~{s2_write, s1_write};
    w_wr = w_acc & {s2_write, s1_write} & w_inr;
    w_we = w_wr & {~(w_wr[0] & (w_addr[0] == w_addr[1])), 1'b1};
  end
  // clear sequencer next state; it only moves on enabled cycles
  always_comb w_nxt = !w_ce ? r_st : r_st == S_IDLE ? (clear_start ? S_CLEAR : S_IDLE) : r_st == S_CLEAR ? (r_cnt == LAST ? S_DONE : S_CLEAR) : S_IDLE;
  // clear state and address counter; counter parks at zero outside CLEAR
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st <= S_IDLE;
      r_cnt <= '0;
    end else begin
      r_st <= w_nxt;
      if (w_ce) r_cnt <= w_busy ? r_cnt + 1'b1 : '0;
    end
  end
  // memory array: clear step or byte-lane port writes; contents survive reset
  always_ff @(posedge clk) begin
    if (w_clr_we) r_mem[r_cnt[IW-1:0]] <= '0;
    for (int b = 0; b < NB; b++) begin
      if (w_we[1] & w_be[1][b]) r_mem[w_idx[1]][b*8 +: 8] <= w_wd[1][b*8 +: 8];
      if (w_we[0] & w_be[0][b]) r_mem[w_idx[0]][b*8 +: 8] <= w_wd[0][b*8 +: 8];
    end
  end
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [READ_LATENCY-1:0] r_v;
    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] r_d;
    // read pipeline; data is forced to zero whenever its valid bit is low
    always_ff @(posedge clk) begin
      if (reset) begin
        r_v <= '0;
        r_d <= '0;
      end else if (w_ce) begin
        r_v[0] <= w_rd[p];
        r_d[0] <= (w_rd[p] & w_inr[p]) ? r_mem[w_idx[p]] : '0;
        for (int i = 1; i < READ_LATENCY; i++) begin
          r_v[i] <= r_v[i-1];
          r_d[i] <= r_d[i-1];
        end
      end
    end
    assign w_rv[p] = r_v[READ_LATENCY-1];
    assign w_rdat[p] = r_d[READ_LATENCY-1];
  end
  assign s1_readdata = w_rdat[0];
  assign s2_readdata = w_rdat[1];
  assign s1_readdatavalid = w_rv[0];
  assign s2_readdatavalid = w_rv[1];
  assign s1_waitrequest = w_busy;
  assign s2_waitrequest = w_busy;
  assign clear_busy = w_busy;
  assign clear_done = r_st == S_DONE;
endmodule
